// File: rtl/dual_rail_pkg.sv
// Shared types and defaults for the dual-rail arbiter: FSM states, rail encodings
// and default parameter values.
package dual_rail_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF     = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RTZ  = 2'd2
    } state_t;

    // Rail pair as {bit1, bit0}; the null code is the return-to-zero spacer
    typedef logic [1:0] rail_t;
    localparam rail_t RAIL_NULL = 2'b00;
    localparam rail_t RAIL_ZERO = 2'b01;
    localparam rail_t RAIL_ONE  = 2'b10;

    function automatic rail_t rail_encode(input logic d);
        return d ? RAIL_ONE : RAIL_ZERO;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing the asynchronous ack into the clk domain.
module sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/dual_rail_arbiter.sv
// Round-robin arbiter for two requesters driving a four-phase dual-rail link.
// Define DUAL_RAIL_ACK_TIMEOUT_EN to bound the ack wait with an err pulse.
module dual_rail_arbiter
    import dual_rail_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic dat0,
    input  logic dat1,
    input  logic ack,
    output logic bit0,
    output logic bit1,
    output logic gnt0,
    output logic gnt1,
    output logic busy,
    output logic err
);

    logic       ack_s;
    state_t     state, state_nxt;
    rail_t      rail_q, rail_nxt;
    logic [1:0] gnt_q, gnt_nxt;
    logic       busy_q;
    logic       win_q, win_nxt;
    logic       last_q, last_nxt;
    logic       elig0, elig1, pick;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack),
        .q     (ack_s)
    );

`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             err_q, err_nxt;
`else
    localparam int unsigned timeout_unused = TIMEOUT;
`endif

    // A requester whose gnt is showing this cycle sits out the arbitration
    assign elig0 = req0 & ~gnt_q[0];
    assign elig1 = req1 & ~gnt_q[1];
    assign pick  = (elig0 & elig1) ? ~last_q : elig1;

    always_comb begin
        state_nxt = state;
        rail_nxt  = rail_q;
        gnt_nxt   = 2'b00;
        win_nxt   = win_q;
        last_nxt  = last_q;
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
        cnt_nxt   = '0;
        err_nxt   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!ack_s && (elig0 || elig1)) begin
                    win_nxt   = pick;
                    rail_nxt  = rail_encode(pick ? dat1 : dat0);
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ack_s) begin
                    rail_nxt  = RAIL_NULL;
                    state_nxt = ST_RTZ;
                end
            end
            ST_RTZ: begin
                if (!ack_s) begin
                    gnt_nxt   = win_q ? 2'b10 : 2'b01;
                    last_nxt  = win_q;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                rail_nxt  = RAIL_NULL;
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
        // Counter restarts on every state change; expiry abandons the transfer
        if (state != ST_IDLE && state_nxt == state) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                rail_nxt  = RAIL_NULL;
                err_nxt   = 1'b1;
                last_nxt  = win_q;
                state_nxt = ST_IDLE;
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            rail_q <= RAIL_NULL;
            gnt_q  <= 2'b00;
            busy_q <= 1'b0;
            win_q  <= 1'b0;
            last_q <= 1'b1;
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
            cnt_q  <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            rail_q <= rail_nxt;
            gnt_q  <= gnt_nxt;
            busy_q <= (state_nxt != ST_IDLE);
            win_q  <= win_nxt;
            last_q <= last_nxt;
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
            cnt_q  <= cnt_nxt;
            err_q  <= err_nxt;
`endif
        end
    end

    assign bit0 = rail_q[0];
    assign bit1 = rail_q[1];
    assign gnt0 = gnt_q[0];
    assign gnt1 = gnt_q[1];
    assign busy = busy_q;
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_arbiter.sv
// Scoreboard bench for dual_rail_arbiter: expected completions are queued when a
// request is driven and retired against gnt/err pulses, with per-cycle invariants.
module tb_dual_rail_arbiter;
    import dual_rail_pkg::*;

`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif
    localparam int WAIT_MAX = 40;

    typedef struct {
        logic  id;
        rail_t rail;
        logic  err;
    } exp_t;

    logic clk, reset, req0, req1, dat0, dat1, ack;
    logic bit0, bit1, gnt0, gnt1, busy, err;

    exp_t  exp_q[$];
    rail_t seen_rail;
    int    checks;
    int    errors;

    dual_rail_arbiter #(
        .SYNC_STAGES (2),
        .TIMEOUT     (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .dat0  (dat0),
        .dat1  (dat1),
        .ack   (ack),
        .bit0  (bit0),
        .bit1  (bit1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariants plus scoreboard retirement, run at every sample point
    task automatic monitor_cycle();
        exp_t       e;
        logic [4:0] want, got;
        checks++;
        if ((bit0 & bit1) !== 1'b0) begin
            errors++;
            $display("FAIL rail_exclusive t=%0t got bit0=%b bit1=%b want not both high", $time, bit0, bit1);
        end
        checks++;
        if ((gnt0 & gnt1) !== 1'b0) begin
            errors++;
            $display("FAIL gnt_exclusive t=%0t got gnt0=%b gnt1=%b want not both high", $time, gnt0, gnt1);
        end
        if (bit0 | bit1) seen_rail = {bit1, bit0};
        if (gnt0 | gnt1 | err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion t=%0t got gnt1/gnt0/err=%b%b%b want none", $time, gnt1, gnt0, err);
            end else begin
                e    = exp_q.pop_front();
                want = {(e.err ? 2'b00 : (e.id ? 2'b10 : 2'b01)), e.rail, e.err};
                got  = {gnt1, gnt0, seen_rail, err};
                if (got !== want) begin
                    errors++;
                    $display("FAIL completion t=%0t got {gnt1,gnt0,rail,err}=%b want %b", $time, got, want);
                end
            end
            seen_rail = RAIL_NULL;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor_cycle();
    endtask

    task automatic push_exp(input logic id, input rail_t rail, input logic e);
        exp_t x;
        x.id   = id;
        x.rail = rail;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; dat0 = 1'b0; dat1 = 1'b0; ack = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        seen_rail = RAIL_NULL;
    endtask

    // Complete one four-phase cycle with a prompt receiver; optionally drop reqs once the rail is up
    task automatic handshake(input bit drop);
        int n;
        n = 0;
        while (!(bit0 | bit1) && n < WAIT_MAX) begin step(); n++; end
        checks++;
        if (!(bit0 | bit1)) begin
            errors++;
            $display("FAIL rail_rise_wait t=%0t got rails=%b%b want a rail high", $time, bit1, bit0);
        end
        if (drop) begin req0 = 1'b0; req1 = 1'b0; end
        ack = 1'b1;
        n = 0;
        while ((bit0 | bit1) && n < WAIT_MAX) begin step(); n++; end
        checks++;
        if ((bit0 | bit1) !== 1'b0) begin
            errors++;
            $display("FAIL rail_fall_wait t=%0t got rails=%b%b want 00", $time, bit1, bit0);
        end
        ack = 1'b0;
        n = 0;
        while (!(gnt0 | gnt1) && n < WAIT_MAX) begin step(); n++; end
        checks++;
        if (!(gnt0 | gnt1)) begin
            errors++;
            $display("FAIL gnt_wait t=%0t got gnt1/gnt0=%b%b want a pulse", $time, gnt1, gnt0);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; dat0 = 1'b0; dat1 = 1'b0; ack = 1'b0;
        repeat (2) step();
        checks++;
        if ({bit1, bit0, gnt1, gnt0, busy, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000", {bit1, bit0, gnt1, gnt0, busy, err});
        end
        reset = 1'b0;
        step();
        seen_rail = RAIL_NULL;
    endtask

    // Cycle-exact single transfer with SYNC_STAGES=2
    task automatic test_single();
        logic [3:0] want, got;
        for (int c = 0; c <= 15; c++) begin
            if (c > 0) step();
            want = {(c >= 1 && c < 8), 1'b0, (c == 13), (c >= 1 && c <= 12)};
            got  = {bit1, bit0, gnt0, busy};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL single_c%0d got {bit1,bit0,gnt0,busy}=%b want %b", c, got, want);
            end
            case (c)
                0:  begin req0 = 1'b1; dat0 = 1'b1; push_exp(1'b0, RAIL_ONE, 1'b0); end
                1:  req0 = 1'b0;
                5:  ack = 1'b1;
                10: ack = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_data();
        int n;
        req0 = 1'b1; dat0 = 1'b1;
        n = 0;
        while (!bit1 && n < WAIT_MAX) begin step(); n++; end
        checks++;
        if (bit1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_rail_wait got bit1=%b want 1", bit1);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bit1, bit0, busy} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_drop got {bit1,bit0,busy}=%b want 000", {bit1, bit0, busy});
        end
        req0 = 1'b0; ack = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        seen_rail = RAIL_NULL;
        req0 = 1'b1; req1 = 1'b1; dat0 = 1'b0; dat1 = 1'b1;
        push_exp(1'b0, RAIL_ZERO, 1'b0);
        push_exp(1'b1, RAIL_ONE, 1'b0);
        handshake(1'b0);
        handshake(1'b1);
    endtask

    task automatic test_contention();
        do_reset();
        req0 = 1'b1; req1 = 1'b1; dat0 = 1'b1; dat1 = 1'b0;
        push_exp(1'b0, RAIL_ONE, 1'b0);
        push_exp(1'b1, RAIL_ZERO, 1'b0);
        push_exp(1'b0, RAIL_ONE, 1'b0);
        push_exp(1'b1, RAIL_ZERO, 1'b0);
        handshake(1'b0);
        handshake(1'b0);
        handshake(1'b0);
        handshake(1'b1);
        repeat (3) step();
    endtask

    task automatic test_stall();
        ack = 1'b1;
        repeat (4) step();
        req1 = 1'b1; dat1 = 1'b1;
        push_exp(1'b1, RAIL_ONE, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({bit1, bit0, busy} !== 3'b000) begin
                errors++;
                $display("FAIL stall_hold_k%0d got {bit1,bit0,busy}=%b want 000", k, {bit1, bit0, busy});
            end
        end
        ack = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({bit1, bit0} !== ((k == 3) ? RAIL_ONE : RAIL_NULL)) begin
                errors++;
                $display("FAIL stall_release_k%0d got rails=%b%b want bit1=%0d", k, bit1, bit0, (k == 3));
            end
        end
        handshake(1'b1);
        repeat (3) step();
    endtask

`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int         n;
        logic [4:0] want, got;
        do_reset();
        req0 = 1'b1; req1 = 1'b1; dat0 = 1'b1; dat1 = 1'b0;
        push_exp(1'b0, RAIL_ONE, 1'b1);
        push_exp(1'b1, RAIL_ZERO, 1'b0);
        n = 0;
        while (!bit1 && n < WAIT_MAX) begin step(); n++; end
        for (int k = 1; k <= 8; k++) begin
            step();
            want = {((k < 8) ? RAIL_ONE : RAIL_NULL), (k == 8), 2'b00};
            got  = {bit1, bit0, err, gnt0, gnt1};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout_k%0d got {bit1,bit0,err,gnt0,gnt1}=%b want %b", k, got, want);
            end
        end
        handshake(1'b1);
        repeat (3) step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        seen_rail = RAIL_NULL;
        test_reset();
        test_single();
        repeat (2) step();
        test_reset_mid_data();
        test_contention();
        test_stall();
`ifdef DUAL_RAIL_ACK_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
